// File: rtl/mem_io_unit_if.sv
// Memory-side handshake between the MAR/MDR unit (master) and the SRAM controller (slave).
interface mem_io_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              Mem_Req;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Ack;

    modport master (
        output Mem_Req, Mem_WE, Mem_Addr, Mem_Wdata,
        input  Mem_Rdata, Mem_Ack
    );

    modport slave (
        input  Mem_Req, Mem_WE, Mem_Addr, Mem_Wdata,
        output Mem_Rdata, Mem_Ack
    );
endinterface

// File: rtl/mem_io_unit.sv
// LC-3 MAR/MDR unit: request/ack memory access with bounded wait, plus a
// memory-mapped Switches/LED slot decoded at IO_ADDR.
module mem_io_unit #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 16,
    parameter int          TIMEOUT = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR = 'hFFFF,
    parameter int          SW_W    = 16,
    parameter int          LED_W   = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic [DATA_W-1:0] Bus_In,
    input  logic              Rd_Req,
    input  logic              Wr_Req,
    input  logic [SW_W-1:0]   Switches,
    mem_io_unit_if.master     mem,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [LED_W-1:0]  LED
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, IO_RD, IO_WR} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             accept, last_wait, finish;

    assign last_wait = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                // Decode uses the MAR held before this edge, not a same-cycle load.
                if (Rd_Req) begin
                    accept  = 1'b1;
                    state_n = (MAR == IO_ADDR) ? IO_RD : MEM_RD;
                end else if (Wr_Req) begin
                    accept  = 1'b1;
                    state_n = (MAR == IO_ADDR) ? IO_WR : MEM_WR;
                end
            end
            MEM_RD, MEM_WR: begin
                if (mem.Mem_Ack || last_wait) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            IO_RD, IO_WR: begin
                finish  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            MAR  <= '0;
            MDR  <= '0;
            LED  <= '0;
            Err  <= 1'b0;
            Done <= 1'b0;
            cnt  <= '0;
        end else begin
            Done <= finish;
            case (state)
                IDLE: begin
                    if (LD_MAR) MAR <= Bus_In[ADDR_W-1:0];
                    if (LD_MDR) MDR <= Bus_In;
                    if (accept) begin
                        Err <= 1'b0;
                        cnt <= '0;
                    end
                end
                MEM_RD, MEM_WR: begin
                    // An ack in the final wait cycle takes precedence over the timeout.
                    if (mem.Mem_Ack) begin
                        if (state == MEM_RD) MDR <= mem.Mem_Rdata;
                    end else if (last_wait) begin
                        Err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IO_RD: MDR <= DATA_W'(Switches);
                IO_WR: LED <= MDR[LED_W-1:0];
                default: ;
            endcase
        end
    end

    assign Busy          = (state != IDLE);
    assign mem.Mem_Req   = (state == MEM_RD) || (state == MEM_WR);
    assign mem.Mem_WE    = (state == MEM_WR);
    assign mem.Mem_Addr  = MAR;
    assign mem.Mem_Wdata = MDR;
endmodule

// File: tb/tb_mem_io_unit.sv
// Bench for mem_io_unit: directed table, reset-mid-access sequence, and
// randomized transactions checked against a transaction-level model.
module tb_mem_io_unit;
    localparam int DW = 16, AW = 16, TO = 8, SWW = 16, LW = 12;

    logic          Clk = 1'b0, Reset = 1'b0;
    logic          LD_MAR = 1'b0, LD_MDR = 1'b0, Rd_Req = 1'b0, Wr_Req = 1'b0;
    logic [DW-1:0] Bus_In = '0;
    logic [SWW-1:0] Switches = '0;
    logic [AW-1:0] MAR;
    logic [DW-1:0] MDR;
    logic          Busy, Done, Err;
    logic [LW-1:0] LED;

    mem_io_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

    mem_io_unit #(
        .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .IO_ADDR(16'hFFFF), .SW_W(SWW), .LED_W(LW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .Bus_In(Bus_In),
        .Rd_Req(Rd_Req), .Wr_Req(Wr_Req), .Switches(Switches), .mem(mbus),
        .MAR(MAR), .MDR(MDR), .Busy(Busy), .Done(Done), .Err(Err), .LED(LED)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          rd;
        bit          both;
        logic [15:0] mar, mdr, sw, rdata;
        int          ack;     // request cycle carrying Mem_Ack; 0 = never acked
        logic [15:0] e_mdr;
        logic [11:0] e_led;
        bit          e_err;
        int          e_req;   // cycles Mem_Req is high
    } txn_t;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected outcome from the access rules alone.
    function automatic txn_t model(input txn_t t, input logic [11:0] led_now);
        txn_t r = t;
        bit rd = t.rd | t.both;
        r.e_led = led_now;
        r.e_err = 1'b0;
        r.e_mdr = t.mdr;
        if (t.mar == 16'hFFFF) begin
            r.e_req = 0;
            if (rd) r.e_mdr = t.sw;
            else    r.e_led = t.mdr[11:0];
        end else if (t.ack >= 1 && t.ack <= TO) begin
            r.e_req = t.ack;
            if (rd) r.e_mdr = t.rdata;
        end else begin
            r.e_req = TO;
            r.e_err = 1'b1;
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t, input string tag);
        bit rd = t.rd | t.both;
        bit io = (t.mar == 16'hFFFF);
        int reqs = 0, cyc = 0, dcyc = 0;
        bit got = 1'b0;
        tick(); LD_MAR = 1'b1; Bus_In = t.mar;
        tick(); LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_In = t.mdr;
        tick(); LD_MDR = 1'b0; Bus_In = '0; Switches = t.sw;
        Rd_Req = rd; Wr_Req = t.both | !t.rd;
        tick(); Rd_Req = 1'b0; Wr_Req = 1'b0;
        while (!got && cyc < 40) begin
            cyc++;
            if (mbus.Mem_Req) begin
                reqs++;
                check({tag, " mem_addr"}, 32'(mbus.Mem_Addr), 32'(t.mar));
                check({tag, " mem_we"}, 32'(mbus.Mem_WE), 32'(!rd));
                if (!rd) check({tag, " mem_wdata"}, 32'(mbus.Mem_Wdata), 32'(t.mdr));
            end
            mbus.Mem_Ack   = mbus.Mem_Req && (reqs == t.ack);
            mbus.Mem_Rdata = t.rdata;
            if (Done) begin
                got  = 1'b1;
                dcyc = cyc;
                check({tag, " busy_at_done"}, 32'(Busy), 32'd0);
            end
            // Loads while busy must be ignored.
            LD_MAR = Busy; LD_MDR = Busy; Bus_In = Busy ? 16'h5555 : 16'h0000;
            if (!got) tick();
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " done_latency"}, 32'(dcyc), io ? 32'd2 : 32'(t.e_req + 1));
        check({tag, " req_cycles"}, 32'(reqs), 32'(t.e_req));
        tick();
        check({tag, " done_pulse"}, 32'(Done), 32'd0);
        check({tag, " mar"}, 32'(MAR), 32'(t.mar));
        check({tag, " mdr"}, 32'(MDR), 32'(t.e_mdr));
        check({tag, " led"}, 32'(LED), 32'(t.e_led));
        check({tag, " err"}, 32'(Err), 32'(t.e_err));
    endtask

    txn_t tbl[9];
    txn_t rt;
    logic [11:0] led_m;

    initial begin
        mbus.Mem_Ack = 1'b0;
        mbus.Mem_Rdata = '0;

        Reset = 1'b0;
        tick(); tick();
        check("rst mar", 32'(MAR), 32'd0);
        check("rst mdr", 32'(MDR), 32'd0);
        check("rst led", 32'(LED), 32'd0);
        check("rst err", 32'(Err), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst req", 32'(mbus.Mem_Req), 32'd0);
        Reset = 1'b1;

        //          rd    both  mar       mdr       sw        rdata     ack  e_mdr     e_led    err   req
        tbl[0] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h0000, 16'hABCD, 3,   16'hABCD, 12'h000, 1'b0, 3};
        tbl[1] = '{1'b0, 1'b0, 16'h0010, 16'h1234, 16'h0000, 16'h9999, 1,   16'h1234, 12'h000, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0055, 16'h0000, 1,   16'h0055, 12'h000, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0ABC, 16'h0000, 16'h0000, 1,   16'h0ABC, 12'hABC, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b0, 16'h0020, 16'h7777, 16'h0000, 16'h1111, 0,   16'h7777, 12'hABC, 1'b1, 8};
        tbl[5] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000, 16'h1111, 1,   16'h1111, 12'hABC, 1'b0, 1};
        tbl[6] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 16'h4242, 2,   16'h4242, 12'hABC, 1'b0, 2};
        tbl[7] = '{1'b0, 1'b0, 16'h0050, 16'h5A5A, 16'h0000, 16'h0000, 8,   16'h5A5A, 12'hABC, 1'b0, 8};
        tbl[8] = '{1'b0, 1'b0, 16'h0060, 16'h0F0F, 16'h0000, 16'h0000, 0,   16'h0F0F, 12'hABC, 1'b1, 8};
        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a memory read abandons it.
        tick(); LD_MAR = 1'b1; Bus_In = 16'h0100;
        tick(); LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_In = 16'h2222;
        tick(); LD_MDR = 1'b0; Rd_Req = 1'b1;
        tick(); Rd_Req = 1'b0;
        tick();
        check("midrd req", 32'(mbus.Mem_Req), 32'd1);
        Reset = 1'b0;
        tick();
        check("midrd rst req", 32'(mbus.Mem_Req), 32'd0);
        check("midrd rst busy", 32'(Busy), 32'd0);
        check("midrd rst mar", 32'(MAR), 32'd0);
        check("midrd rst mdr", 32'(MDR), 32'd0);
        check("midrd rst led", 32'(LED), 32'd0);
        check("midrd rst err", 32'(Err), 32'd0);
        tick();
        Reset = 1'b1;
        tick();
        check("midrd post busy", 32'(Busy), 32'd0);
        check("midrd post done", 32'(Done), 32'd0);

        led_m = '0;
        for (int i = 0; i < 40; i++) begin
            rt.rd    = $urandom_range(0, 1) == 1;
            rt.both  = $urandom_range(0, 3) == 0;
            rt.mar   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
            rt.mdr   = 16'($urandom);
            rt.sw    = 16'($urandom);
            rt.rdata = 16'($urandom);
            rt.ack   = $urandom_range(0, TO);
            rt = model(rt, led_m);
            run_txn(rt, $sformatf("rnd%0d", i));
            led_m = rt.e_led;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
